// File: rtl/element_mult_chain.sv
// element_mult_chain: streaming multi-lane Q-format element-wise product across operand groups
// Each lane keeps a saturating running product; groups are framed by first/last flags.
module element_mult_chain #(
  parameter int LANES    = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 8
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [LANES*W-1:0]   out_data,
  output logic [CNT_W-1:0]     out_count,
  input  logic                 out_ready,
  output logic                 proto_err
);
  localparam int MW = $clog2(MULT_LAT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MULT, S_OUT} state_t;
  state_t               r_state;
  logic [LANES*W-1:0]   r_acc, r_opnd, w_prod;
  logic                 r_last, r_err;
  logic [CNT_W-1:0]     r_cnt;
  logic [MW-1:0]        r_mcnt;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [2*W-1:0] w_a, w_b, w_p, w_r;
    assign w_a = {{W{r_acc[i*W+W-1]}}, r_acc[i*W +: W]};
    assign w_b = {{W{r_opnd[i*W+W-1]}}, r_opnd[i*W +: W]};
    assign w_p = w_a * w_b;
    assign w_r = w_p >>> FRAC;
    // in range when the bits above the result's sign bit all match it
    assign w_prod[i*W +: W] = (&w_r[2*W-1:W-1] || ~|w_r[2*W-1:W-1]) ? w_r[W-1:0]
                              : {w_r[2*W-1], {(W-1){~w_r[2*W-1]}}};
  end
  assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACC);
  assign out_valid = r_state == S_OUT;
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign proto_err = r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_mcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= in_valid && in_ready && ((r_state == S_IDLE) ? !in_first : in_first);
      case (r_state)
        S_IDLE, S_ACC: if (in_valid) begin
          if (in_first) begin
            r_acc   <= in_data;
            r_cnt   <= CNT_W'(1);
            r_state <= in_last ? S_OUT : S_ACC;
          end else if (r_state == S_ACC) begin
            r_opnd  <= in_data;
            r_last  <= in_last;
            r_mcnt  <= MW'(MULT_LAT);
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_mcnt <= r_mcnt - MW'(1);
          if (r_mcnt == MW'(1)) begin
            r_acc   <= w_prod;
            r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            r_state <= r_last ? S_OUT : S_ACC;
          end
        end
        default: if (out_ready) r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_element_mult_chain.sv
// tb_element_mult_chain: directed and randomized checks of element_mult_chain
// against an arithmetic reference of the saturating per-lane group product.
module tb_element_mult_chain;
  localparam int LANES = 4, W = 16, FRAC = 8, ML = 2, CNT_W = 8, DW = LANES * W;
  logic clk = 0, reset_n = 0, in_valid = 0, in_first = 0, in_last = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, proto_err;
  logic [DW-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  int tests = 0, fails = 0;
  logic [DW-1:0] ops[$];

  element_mult_chain #(.LANES(LANES), .W(W), .FRAC(FRAC), .MULT_LAT(ML), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_count(out_count), .out_ready(out_ready), .proto_err(proto_err));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lv(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [DW-1:0] ref_prod();
    logic [DW-1:0] res;
    logic signed [W-1:0] v;
    longint a, b, mx, mn;
    res = '0;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -(longint'(1) << (W - 1));
    for (int i = 0; i < LANES; i++) begin
      v = ops[0][i*W +: W];
      a = v;
      for (int k = 1; k < ops.size(); k++) begin
        v = ops[k][i*W +: W];
        b = v;
        a = (a * b) >>> FRAC;
        a = (a > mx) ? mx : (a < mn) ? mn : a;
      end
      res[i*W +: W] = a[W-1:0];
    end
    return res;
  endfunction

  task automatic send_beat(input logic f, input logic l, input logic [DW-1:0] d);
    int k = 0;
    in_valid = 1; in_first = f; in_last = l; in_data = d;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_beat in_ready got %b required 1 within 100 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic check_result(input string name, input logic [DW-1:0] ed, input int ec,
                              input int el, input bit hold);
    int n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    tests++;
    if (out_valid !== 1'b1 || n + 1 != el) begin
      fails++;
      $display("FAIL %s latency got %0d (out_valid=%b) required %0d", name, n + 1, out_valid, el);
    end
    tests++;
    if (out_data !== ed) begin
      fails++;
      $display("FAIL %s out_data got %h required %h", name, out_data, ed);
    end
    tests++;
    if (out_count !== CNT_W'(ec)) begin
      fails++;
      $display("FAIL %s out_count got %0d required %0d", name, out_count, ec);
    end
    if (hold) repeat (5) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== ed || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold valid=%b data=%h in_ready=%b required 1 %h 0",
                 name, out_valid, out_data, in_ready, ed);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s out_valid after transfer got %b required 0", name, out_valid);
    end
  endtask

  task automatic run_group(input string name, input bit hold);
    logic [DW-1:0] ed;
    int ec;
    ed = ref_prod();
    ec = (ops.size() > 255) ? 255 : ops.size();
    for (int k = 0; k < ops.size(); k++) send_beat(k == 0, k == ops.size() - 1, ops[k]);
    check_result(name, ed, ec, (ops.size() == 1) ? 1 : ML + 1, hold);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (out_valid !== 0 || out_data !== '0 || out_count !== '0 || proto_err !== 0) begin
      fails++;
      $display("FAIL reset outputs valid=%b data=%h count=%0d err=%b required all 0",
               out_valid, out_data, out_count, proto_err);
    end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset in_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_two_operand();
    send_beat(1, 0, lv(16'h0180, 16'h0100, 16'h0040, 16'hFF00));
    send_beat(0, 1, lv(16'h0200, 16'h0300, 16'h0200, 16'h0200));
    check_result("two_operand", lv(16'h0300, 16'h0300, 16'h0080, 16'hFE00), 2, ML + 1, 0);
  endtask

  task automatic test_three_operand();
    send_beat(1, 0, lv(16'h0100, 16'hFE80, 16'h7F00, 16'h8000));
    send_beat(0, 0, lv(16'h0100, 16'h0200, 16'h0400, 16'h0200));
    send_beat(0, 1, lv(16'h0100, 16'h0100, 16'h0100, 16'h0100));
    check_result("three_operand", lv(16'h0100, 16'hFD00, 16'h7FFF, 16'h8000), 3, ML + 1, 0);
  endtask

  task automatic test_truncation();
    send_beat(1, 0, lv(16'h0001, 16'hFFFF, 16'h0100, 16'hFF00));
    send_beat(0, 1, lv(16'h0080, 16'h0080, 16'h0100, 16'hFF00));
    check_result("truncation", lv(16'h0000, 16'hFFFF, 16'h0100, 16'h0100), 2, ML + 1, 0);
  endtask

  task automatic test_single_hold();
    send_beat(1, 1, lv(16'h1234, 16'h1234, 16'h1234, 16'h1234));
    check_result("single_hold", lv(16'h1234, 16'h1234, 16'h1234, 16'h1234), 1, 1, 1);
  endtask

  task automatic test_framing_idle();
    send_beat(0, 1, lv(16'h0500, 16'h0500, 16'h0500, 16'h0500));
    tests++;
    if (proto_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL framing_idle err=%b valid=%b in_ready=%b required 1 0 1",
               proto_err, out_valid, in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (proto_err !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL framing_idle pulse err=%b valid=%b required 0 0", proto_err, out_valid);
    end
  endtask

  task automatic test_restart();
    send_beat(1, 0, lv(16'h0500, 16'h0500, 16'h0500, 16'h0500));
    send_beat(1, 0, lv(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL restart proto_err got %b required 1", proto_err);
    end
    send_beat(0, 1, lv(16'h0300, 16'h0300, 16'h0300, 16'h0300));
    check_result("restart", lv(16'h0600, 16'h0600, 16'h0600, 16'h0600), 2, ML + 1, 0);
  endtask

  task automatic test_reset_mid();
    send_beat(1, 0, lv(16'h0100, 16'h0100, 16'h0100, 16'h0100));
    send_beat(0, 0, lv(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    #2 reset_n = 0;
    #1;
    tests++;
    if (out_valid !== 0 || out_data !== '0 || out_count !== '0 || proto_err !== 0) begin
      fails++;
      $display("FAIL reset_mid outputs valid=%b data=%h count=%0d err=%b required all 0",
               out_valid, out_data, out_count, proto_err);
    end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    send_beat(1, 0, lv(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    send_beat(0, 1, lv(16'h0200, 16'h0200, 16'h0200, 16'h0200));
    check_result("reset_mid", lv(16'h0400, 16'h0400, 16'h0400, 16'h0400), 2, ML + 1, 0);
  endtask

  task automatic test_count_saturation();
    logic [DW-1:0] first;
    first = {$urandom, $urandom};
    send_beat(1, 0, first);
    for (int k = 1; k < 260; k++) send_beat(0, k == 259, lv(16'h0100, 16'h0100, 16'h0100, 16'h0100));
    check_result("count_saturation", first, 255, ML + 1, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int g = 0; g < 25; g++) begin
      ops.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) begin
          v = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 16'h600)) - W'(16'h300);
          d[i*W +: W] = v;
        end
        ops.push_back(d);
      end
      run_group("random", bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_two_operand();
    test_three_operand();
    test_truncation();
    test_single_hold();
    test_framing_idle();
    test_restart();
    test_reset_mid();
    test_count_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
